sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Two-requester arbiter sharing the single SDRAM controller port of the SoC, for example between the CPU memory port and a DMA/SPI-streaming engine. It sits between the requesters and the 16-bit SDRAM controller that drives the SDRAM pad group. Arbitration is round-robin, and each granted transaction is registered before issue. An optional per-requester lock keeps ownership across consecutive transactions (RV32A LR/SC and AMO read-modify-write sequences), bounded by a hold limit so the other requester cannot starve.

## Interface
- ADDR_W, 25, byte address width (32 MB SDRAM)
- LOCK_MAX, 16, maximum cycles one requester may hold ownership under lock; counter width $clog2(LOCK_MAX+1)

Ports (all payload widths fixed 32-bit data, 4-bit strobe):
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- r0_valid / r1_valid  in  1  request; held high with stable payload until the matching ready
- r0_lock / r1_lock  in  1  retain ownership after the current transaction
- r0_addr / r1_addr  in  ADDR_W  byte address
- r0_wdata / r1_wdata  in  32  write data
- r0_wstrb / r1_wstrb  in  4  byte strobes; 0 = read
- r0_ready / r1_ready  out  1  one-cycle completion pulse
- r0_rdata / r1_rdata  out  32  read data, valid only while the matching ready is high
- m_valid  out  1  registered request to the SDRAM controller
- m_addr  out  ADDR_W  registered address
- m_wdata  out  32  registered write data
- m_wstrb  out  4  registered strobes
- m_ready  in  1  controller completion
- m_rdata  in  32  controller read data
- busy  out  1  high when state is not IDLE
- grant_id  out  1  current or last owner

## Operation
- State machine has three states:
  - IDLE: no owner.
  - ISSUE: m_valid high, waiting for m_ready.
  - LOCKED: owner retains the port between transactions.
- Registers: state, owner, last_owner, hold_cnt (saturating), and the m_* payload.
- IDLE:
  - Exactly one rX_valid: grant X.
  - Both valid: grant the requester that is not last_owner.
  - On grant: latch X's addr/wdata/wstrb into m_*, set owner=X, clear hold_cnt, go to ISSUE.
- ISSUE:
  - m_valid=1 and m_* stay stable until m_ready.
  - hold_cnt increments every cycle.
  - rX_ready = (state==ISSUE) & m_ready & (owner==X), combinational.
  - rX_rdata = m_rdata, combinational, broadcast to both requesters.
  - On m_ready: set last_owner=owner. If r<owner>_lock=1 and hold_cnt<LOCK_MAX, go to LOCKED; otherwise go to IDLE.
- LOCKED, evaluated in this priority order:
  1. r<owner>_lock=0 or hold_cnt>=LOCK_MAX: go to IDLE, even if owner valid is high this cycle.
  2. Owner valid: latch payload, go to ISSUE. hold_cnt is not cleared.
  3. Otherwise: stay in LOCKED with hold_cnt incrementing.
- The non-owner's valid is ignored while the state is ISSUE or LOCKED.
- m_ready while in IDLE or LOCKED is ignored; no ready pulse is produced.
- Requester contract: deassert valid the cycle after ready unless issuing a new request. Valid still high in the next cycle counts as a new request.
- m_* payload holds its last value when idle. Only m_valid qualifies it.
- Reset (asynchronous, may arrive at any time, including mid-transaction):
  - state=IDLE, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0.
  - owner=0, grant_id=0, last_owner=1 (r0 wins the first tie), hold_cnt=0, busy=0.
  - r*_ready=0.
  - An in-flight transaction is abandoned without a ready pulse.

## Timing
- Grant latency: rX_valid sampled in IDLE at edge t gives m_valid=1 from t+1.
- Completion: m_ready high in cycle c gives rX_ready in the same cycle c. m_valid is 0 from c+1 (IDLE) unless the lock path continues.
- Unlocked back-to-back: completion at c, IDLE at c+1, next m_valid at c+2. Minimum 2 cycles between m_valid periods.
- Locked back-to-back: completion at c, LOCKED at c+1; owner valid at c+1 gives m_valid at c+2.
- hold_cnt saturates at LOCK_MAX. The limit is only enforced at transaction boundaries; a transaction in ISSUE is never aborted.
- grant_id and busy are registered, updated on the same edge as state.

## Test plan
- Single read: r0_valid with addr=0x000100, wstrb=0. m_ready after 3 cycles with m_rdata=0xDEADBEEF. Required: m_valid rises 1 cycle after request, r0_ready pulses once with r0_rdata=0xDEADBEEF, r1_ready stays 0.
- Simultaneous requests after reset: r0 and r1 both valid every cycle, m_ready=1 one cycle after each m_valid. Required: grant order r0,r1,r0,r1; m_addr alternates between the two addresses.
- Lock sequence: r1 raises lock, then does LR read followed by SC write (wstrb=0xF, wdata=0x12345678) while r0 is continuously valid. Required: both r1 transactions complete before any r0 grant; after r1 drops lock, r0 is granted within 2 cycles.
- Lock starvation bound: LOCK_MAX=16, r0 holds lock permanently and issues requests, r1 valid. Required: r1 granted no later than the first transaction boundary with hold_cnt>=16.
- Reset mid-transaction: assert rst while in ISSUE with m_valid=1. Required: m_valid=0, busy=0, grant_id=0, no ready pulse. After release, a pending r0/r1 tie grants r0.
- Spurious m_ready in IDLE/LOCKED: pulse m_ready with no transaction outstanding. Required: no rX_ready, state unchanged.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that lets two requesters share one SDRAM controller port.
// An optional per-requester lock keeps ownership across transactions, bounded by LOCK_MAX.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [3:0]        r0_wstrb,
    output logic              r0_ready,
    output logic [31:0]       r0_rdata,
    input  logic              r1_valid,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [3:0]        r1_wstrb,
    output logic              r1_ready,
    output logic [31:0]       r1_rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata,
    output logic              busy,
    output logic              grant_id,
    output logic [1:0]        state_dbg
);
    // Handshake: a requester holds valid and a stable payload until its one-cycle
    // ready pulse; valid still high on the following cycle is a new request.
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             load;
    logic             owner_lock;
    logic             owner_valid;

    assign owner_lock  = owner_q ? r1_lock  : r0_lock;
    assign owner_valid = owner_q ? r1_valid : r0_valid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        load    = 1'b0;
        hold_d  = hold_q;
        // hold_cnt runs while ownership is held and saturates at the limit
        if (state_q != IDLE && hold_q != LOCK_LIM) begin
            hold_d = hold_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    owner_d = (r0_valid && r1_valid) ? ~last_q : r1_valid;
                    load    = 1'b1;
                    hold_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (m_ready) begin
                    last_d  = owner_q;
                    state_d = (owner_lock && hold_q < LOCK_LIM) ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (!owner_lock || hold_q >= LOCK_LIM) begin
                    state_d = IDLE;
                end else if (owner_valid) begin
                    load    = 1'b1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            hold_q  <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            if (load) begin
                m_addr  <= owner_d ? r1_addr  : r0_addr;
                m_wdata <= owner_d ? r1_wdata : r0_wdata;
                m_wstrb <= owner_d ? r1_wstrb : r0_wstrb;
            end
        end
    end

    assign m_valid   = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign grant_id  = owner_q;
    assign state_dbg = state_q;

    assign r0_ready = (state_q == ISSUE) && m_ready && !owner_q;
    assign r1_ready = (state_q == ISSUE) && m_ready &&  owner_q;
    assign r0_rdata = m_rdata;
    assign r1_rdata = m_rdata;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant order, lock hold, hold limit,
// reset mid-transaction and spurious controller completions.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              r0_valid = 0, r0_lock = 0, r1_valid = 0, r1_lock = 0;
    logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
    logic [31:0]       r0_wdata = '0, r1_wdata = '0;
    logic [3:0]        r0_wstrb = '0, r1_wstrb = '0;
    logic              r0_ready, r1_ready;
    logic [31:0]       r0_rdata, r1_rdata;
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_ready = 1'b0;
    logic [31:0]       m_rdata = '0;
    logic              busy, grant_id;
    logic [1:0]        state_dbg;

    int n_vec = 0;
    int n_err = 0;

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb), .r0_ready(r0_ready), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb), .r1_ready(r1_ready), .r1_rdata(r1_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int r0_cnt;
        logic seen_r1;
        logic [ADDR_W-1:0] a0, a1, ea;
        logic eg;

        // reset state
        #1;
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_addr", 32'(m_addr), 0);
        check("rst_state", 32'(state_dbg), 0);
        tick();
        rst = 1'b0;

        // single read
        tick();
        r0_valid = 1; r0_addr = 25'h000100; r0_wstrb = 4'h0;
        #1 check("rd_pre_m_valid", 32'(m_valid), 0);
        tick();
        check("rd_m_valid", 32'(m_valid), 1);
        check("rd_m_addr", 32'(m_addr), 32'h100);
        check("rd_m_wstrb", 32'(m_wstrb), 0);
        check("rd_busy", 32'(busy), 1);
        tick();
        tick();
        m_ready = 1; m_rdata = 32'hDEADBEEF;
        #1;
        check("rd_r0_ready", 32'(r0_ready), 1);
        check("rd_r0_rdata", r0_rdata, 32'hDEADBEEF);
        check("rd_r1_ready", 32'(r1_ready), 0);
        tick();
        r0_valid = 0; m_ready = 0;
        #1;
        check("rd_done_m_valid", 32'(m_valid), 0);
        check("rd_done_busy", 32'(busy), 0);
        check("rd_done_r0_ready", 32'(r0_ready), 0);

        // spurious completion while idle
        m_ready = 1;
        #1;
        check("sp_idle_r0_ready", 32'(r0_ready), 0);
        check("sp_idle_r1_ready", 32'(r1_ready), 0);
        tick();
        m_ready = 0;
        check("sp_idle_state", 32'(state_dbg), 0);
        check("sp_idle_m_valid", 32'(m_valid), 0);

        // simultaneous requests after reset alternate r0,r1,r0,r1
        rst = 1;
        tick();
        rst = 0;
        a0 = 25'h001000; a1 = 25'h002000;
        r0_valid = 1; r0_addr = a0; r1_valid = 1; r1_addr = a1;
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 1);
            ea = eg ? a1 : a0;
            tick();
            check($sformatf("rr%0d_m_valid", i), 32'(m_valid), 1);
            check($sformatf("rr%0d_grant", i), 32'(grant_id), 32'(eg));
            check($sformatf("rr%0d_addr", i), 32'(m_addr), 32'(ea));
            m_ready = 1;
            #1;
            check($sformatf("rr%0d_r0_ready", i), 32'(r0_ready), 32'(!eg));
            check($sformatf("rr%0d_r1_ready", i), 32'(r1_ready), 32'(eg));
            tick();
            m_ready = 0;
            check($sformatf("rr%0d_gap", i), 32'(m_valid), 0);
        end
        r0_valid = 0; r1_valid = 0;

        // lock sequence: r1 LR then SC while r0 waits
        tick();
        r1_valid = 1; r1_lock = 1; r1_addr = 25'h000300; r1_wstrb = 4'h0;
        tick();
        check("lk_lr_grant", 32'(grant_id), 1);
        check("lk_lr_m_valid", 32'(m_valid), 1);
        r0_valid = 1; r0_addr = 25'h000400; r0_wstrb = 4'h0;
        m_ready = 1; m_rdata = 32'h0000CAFE;
        #1;
        check("lk_lr_r1_ready", 32'(r1_ready), 1);
        check("lk_lr_r1_rdata", r1_rdata, 32'h0000CAFE);
        check("lk_lr_r0_ready", 32'(r0_ready), 0);
        tick();
        r1_valid = 0;
        check("lk_locked_state", 32'(state_dbg), 2);
        check("lk_locked_m_valid", 32'(m_valid), 0);
        check("lk_locked_busy", 32'(busy), 1);
        #1;
        check("sp_lk_r0_ready", 32'(r0_ready), 0);
        check("sp_lk_r1_ready", 32'(r1_ready), 0);
        tick();
        m_ready = 0;
        check("sp_lk_state", 32'(state_dbg), 2);
        check("sp_lk_grant", 32'(grant_id), 1);
        r1_valid = 1; r1_wstrb = 4'hF; r1_wdata = 32'h12345678;
        tick();
        check("lk_sc_grant", 32'(grant_id), 1);
        check("lk_sc_m_valid", 32'(m_valid), 1);
        check("lk_sc_wdata", m_wdata, 32'h12345678);
        check("lk_sc_wstrb", 32'(m_wstrb), 32'hF);
        r1_lock = 0; m_ready = 1;
        #1;
        check("lk_sc_r1_ready", 32'(r1_ready), 1);
        check("lk_sc_r0_ready", 32'(r0_ready), 0);
        tick();
        r1_valid = 0; m_ready = 0;
        check("lk_release_state", 32'(state_dbg), 0);
        tick();
        check("lk_r0_grant", 32'(grant_id), 0);
        check("lk_r0_m_valid", 32'(m_valid), 1);
        check("lk_r0_addr", 32'(m_addr), 32'h400);
        m_ready = 1;
        tick();
        r0_valid = 0; m_ready = 0;

        // hold limit: r0 locked and always valid, r1 waiting
        tick();
        r0_valid = 1; r0_lock = 1;
        tick();
        r1_valid = 1; r1_addr = 25'h000500;
        r0_cnt = 0;
        seen_r1 = 0;
        for (int c = 0; c < 60 && !seen_r1; c++) begin
            if (m_valid && grant_id) begin
                seen_r1 = 1;
            end else begin
                if (m_valid) r0_cnt++;
                m_ready = m_valid;
                tick();
            end
        end
        m_ready = 0;
        check("hold_r1_granted", 32'(seen_r1), 1);
        check("hold_r0_lock_kept", 32'(r0_cnt >= 9), 1);
        check("hold_r0_bounded", 32'(r0_cnt <= 17), 1);
        check("hold_r1_addr", 32'(m_addr), 32'h500);

        // reset while r1's transaction is in flight
        r0_lock = 0;
        m_ready = 1; rst = 1;
        #1;
        check("mrst_m_valid", 32'(m_valid), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_grant", 32'(grant_id), 0);
        check("mrst_r1_ready", 32'(r1_ready), 0);
        check("mrst_r0_ready", 32'(r0_ready), 0);
        tick();
        rst = 0; m_ready = 0;
        tick();
        check("mrst_tie_grant", 32'(grant_id), 0);
        check("mrst_tie_m_valid", 32'(m_valid), 1);
        check("mrst_tie_addr", 32'(m_addr), 32'h400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
